// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Drives the PLL reset, qualifies the asynchronous locked flag
//               and holds the downstream reset until lock has been stable.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 500000,
    parameter int STABLE_CYCLES  = 50000,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 pll_locked,
    output logic                 pll_rst,
    output logic                 sys_rst,
    output logic                 lock_ok,
    output logic [CNT_WIDTH-1:0] loss_count,
    output logic [CNT_WIDTH-1:0] retry_count,
    output logic [1:0]           state_o
);

    localparam int C_MAX_AB = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int C_MAX    = (C_MAX_AB > PLL_RST_CYCLES) ? C_MAX_AB : PLL_RST_CYCLES;
    localparam int TMR_W    = (C_MAX > 1) ? $clog2(C_MAX) : 1;

    localparam logic [TMR_W-1:0] C_RST_LAST    = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] C_TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] C_STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PLL_RESET = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABILIZE = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 sync1_q, lk_s_q;
    logic [CNT_WIDTH-1:0] loss_q, loss_d;
    logic [CNT_WIDTH-1:0] retry_q, retry_d;
    logic                 loss_inc, retry_inc;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= ST_PLL_RESET;
            timer_q <= '0;
            sync1_q <= 1'b0;
            lk_s_q  <= 1'b0;
            loss_q  <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sync1_q <= pll_locked;
            lk_s_q  <= sync1_q;
            loss_q  <= loss_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        loss_inc  = 1'b0;
        retry_inc = 1'b0;
        case (state_q)
            ST_PLL_RESET: begin
                if (timer_q == C_RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // A lock seen on the final timeout cycle still wins.
                if (lk_s_q) begin
                    state_d = ST_STABILIZE;
                end else if (timer_q == C_TIMEOUT_LAST) begin
                    state_d   = ST_PLL_RESET;
                    retry_inc = 1'b1;
                end
            end
            ST_STABILIZE: begin
                if (!lk_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (timer_q == C_STABLE_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lk_s_q) begin
                    state_d  = ST_WAIT_LOCK;
                    loss_inc = 1'b1;
                end
            end
            default: state_d = ST_PLL_RESET;
        endcase

        // The timer free-runs in RUN; its value is unused there.
        timer_d = (state_d != state_q) ? '0 : timer_q + TMR_W'(1);
        loss_d  = (loss_inc && (loss_q != '1)) ? loss_q + CNT_WIDTH'(1) : loss_q;
        retry_d = (retry_inc && (retry_q != '1)) ? retry_q + CNT_WIDTH'(1) : retry_q;
    end

    assign pll_rst     = (state_q == ST_PLL_RESET);
    assign sys_rst     = (state_q != ST_RUN);
    assign lock_ok     = (state_q == ST_RUN);
    assign state_o     = state_q;
    assign loss_count  = loss_q;
    assign retry_count = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_supervisor
// Description : Scoreboard bench for pll_lock_supervisor with short timings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          refclk;
    logic          rst;
    logic          pll_locked;
    logic          pll_rst;
    logic          sys_rst;
    logic          lock_ok;
    logic [CW-1:0] loss_count;
    logic [CW-1:0] retry_count;
    logic [1:0]    state_o;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .CNT_WIDTH     (CW)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .lock_ok    (lock_ok),
        .loss_count (loss_count),
        .retry_count(retry_count),
        .state_o    (state_o)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // One entry per clock: inputs applied before the edge, outputs expected after it.
    typedef struct {
        logic          rst;
        logic          lk;
        logic [1:0]    st;
        logic          prst;
        logic          srst;
        logic          lok;
        logic [CW-1:0] loss;
        logic [CW-1:0] retry;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic void push(input logic r, input logic l, input logic [1:0] s,
                                 input int n, input int loss, input int retry);
        exp_t e;
        e.rst   = r;
        e.lk    = l;
        e.st    = s;
        e.prst  = (s == 2'd0);
        e.srst  = (s != 2'd3);
        e.lok   = (s == 2'd3);
        e.loss  = CW'(sat(loss));
        e.retry = CW'(sat(retry));
        for (int i = 0; i < n; i++) sb.push_back(e);
    endfunction

    task automatic test_reset();
        exp_t e;
        int   step = 0;
        push(1, 0, 0, 3, 0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.rst; pll_locked = e.lk;
            @(posedge refclk); #1;
            n_checks++; step++;
            if ({state_o, pll_rst, sys_rst, lock_ok, loss_count, retry_count} !==
                {e.st, e.prst, e.srst, e.lok, e.loss, e.retry}) begin
                n_fail++;
                $display("FAIL reset step %0d: got st=%0d prst=%b srst=%b ok=%b loss=%0d retry=%0d, want st=%0d prst=%b srst=%b ok=%b loss=%0d retry=%0d",
                         step, state_o, pll_rst, sys_rst, lock_ok, loss_count, retry_count,
                         e.st, e.prst, e.srst, e.lok, e.loss, e.retry);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   step = 0;
        push(0, 0, 0, 3, 0, 0);
        push(0, 0, 1, 32, 0, 0);
        push(0, 0, 0, 4, 0, 1);
        push(0, 0, 1, 1, 0, 1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.rst; pll_locked = e.lk;
            @(posedge refclk); #1;
            n_checks++; step++;
            if ({state_o, pll_rst, sys_rst, lock_ok, loss_count, retry_count} !==
                {e.st, e.prst, e.srst, e.lok, e.loss, e.retry}) begin
                n_fail++;
                $display("FAIL timeout step %0d: got st=%0d prst=%b srst=%b ok=%b loss=%0d retry=%0d, want st=%0d prst=%b srst=%b ok=%b loss=%0d retry=%0d",
                         step, state_o, pll_rst, sys_rst, lock_ok, loss_count, retry_count,
                         e.st, e.prst, e.srst, e.lok, e.loss, e.retry);
            end
        end
    endtask

    task automatic test_lock_latency();
        exp_t e;
        int   step = 0;
        push(0, 0, 1, 10, 0, 1);
        push(0, 1, 1, 2, 0, 1);
        push(0, 1, 2, 8, 0, 1);
        push(0, 1, 3, 1, 0, 1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.rst; pll_locked = e.lk;
            @(posedge refclk); #1;
            n_checks++; step++;
            if ({state_o, pll_rst, sys_rst, lock_ok, loss_count, retry_count} !==
                {e.st, e.prst, e.srst, e.lok, e.loss, e.retry}) begin
                n_fail++;
                $display("FAIL lock_latency step %0d: got st=%0d prst=%b srst=%b ok=%b loss=%0d retry=%0d, want st=%0d prst=%b srst=%b ok=%b loss=%0d retry=%0d",
                         step, state_o, pll_rst, sys_rst, lock_ok, loss_count, retry_count,
                         e.st, e.prst, e.srst, e.lok, e.loss, e.retry);
            end
        end
    endtask

    // Glitch lands so the loss is seen on the last window cycle: loss must win.
    task automatic test_glitch();
        exp_t e;
        int   step = 0;
        push(1, 1, 0, 1, 0, 0);
        push(0, 1, 0, 3, 0, 0);
        push(0, 1, 1, 1, 0, 0);
        push(0, 1, 2, 6, 0, 0);
        push(0, 0, 2, 1, 0, 0);
        push(0, 1, 2, 1, 0, 0);
        push(0, 1, 1, 1, 0, 0);
        push(0, 1, 2, 8, 0, 0);
        push(0, 1, 3, 1, 0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.rst; pll_locked = e.lk;
            @(posedge refclk); #1;
            n_checks++; step++;
            if ({state_o, pll_rst, sys_rst, lock_ok, loss_count, retry_count} !==
                {e.st, e.prst, e.srst, e.lok, e.loss, e.retry}) begin
                n_fail++;
                $display("FAIL glitch step %0d: got st=%0d prst=%b srst=%b ok=%b loss=%0d retry=%0d, want st=%0d prst=%b srst=%b ok=%b loss=%0d retry=%0d",
                         step, state_o, pll_rst, sys_rst, lock_ok, loss_count, retry_count,
                         e.st, e.prst, e.srst, e.lok, e.loss, e.retry);
            end
        end
    endtask

    task automatic test_run_loss();
        exp_t e;
        int   step = 0;
        for (int i = 0; i < 5; i++) begin
            push(0, 0, 3, 2, i, 0);
            push(0, 0, 1, 1, i + 1, 0);
            push(0, 1, 1, 2, i + 1, 0);
            push(0, 1, 2, 8, i + 1, 0);
            push(0, 1, 3, 1, i + 1, 0);
        end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.rst; pll_locked = e.lk;
            @(posedge refclk); #1;
            n_checks++; step++;
            if ({state_o, pll_rst, sys_rst, lock_ok, loss_count, retry_count} !==
                {e.st, e.prst, e.srst, e.lok, e.loss, e.retry}) begin
                n_fail++;
                $display("FAIL run_loss step %0d: got st=%0d prst=%b srst=%b ok=%b loss=%0d retry=%0d, want st=%0d prst=%b srst=%b ok=%b loss=%0d retry=%0d",
                         step, state_o, pll_rst, sys_rst, lock_ok, loss_count, retry_count,
                         e.st, e.prst, e.srst, e.lok, e.loss, e.retry);
            end
        end
    endtask

    task automatic test_retry_saturate();
        exp_t e;
        int   step = 0;
        push(0, 0, 3, 2, 3, 0);
        push(0, 0, 1, 1, 3, 0);
        for (int k = 0; k < 5; k++) begin
            push(0, 0, 1, 31, 3, k);
            push(0, 0, 0, 4, 3, k + 1);
            push(0, 0, 1, 1, 3, k + 1);
        end
        push(0, 1, 1, 2, 3, 5);
        push(0, 1, 2, 8, 3, 5);
        push(0, 1, 3, 1, 3, 5);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.rst; pll_locked = e.lk;
            @(posedge refclk); #1;
            n_checks++; step++;
            if ({state_o, pll_rst, sys_rst, lock_ok, loss_count, retry_count} !==
                {e.st, e.prst, e.srst, e.lok, e.loss, e.retry}) begin
                n_fail++;
                $display("FAIL retry_saturate step %0d: got st=%0d prst=%b srst=%b ok=%b loss=%0d retry=%0d, want st=%0d prst=%b srst=%b ok=%b loss=%0d retry=%0d",
                         step, state_o, pll_rst, sys_rst, lock_ok, loss_count, retry_count,
                         e.st, e.prst, e.srst, e.lok, e.loss, e.retry);
            end
        end
    endtask

    task automatic test_reset_in_run();
        exp_t e;
        int   step = 0;
        push(1, 1, 0, 1, 0, 0);
        push(0, 1, 0, 3, 0, 0);
        push(0, 1, 1, 1, 0, 0);
        push(0, 1, 2, 1, 0, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            rst = e.rst; pll_locked = e.lk;
            @(posedge refclk); #1;
            n_checks++; step++;
            if ({state_o, pll_rst, sys_rst, lock_ok, loss_count, retry_count} !==
                {e.st, e.prst, e.srst, e.lok, e.loss, e.retry}) begin
                n_fail++;
                $display("FAIL reset_in_run step %0d: got st=%0d prst=%b srst=%b ok=%b loss=%0d retry=%0d, want st=%0d prst=%b srst=%b ok=%b loss=%0d retry=%0d",
                         step, state_o, pll_rst, sys_rst, lock_ok, loss_count, retry_count,
                         e.st, e.prst, e.srst, e.lok, e.loss, e.retry);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        test_reset();
        test_timeout();
        test_lock_latency();
        test_glitch();
        test_run_loss();
        test_retry_saturate();
        test_reset_in_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
